// File: rtl/pong_pkg.sv
// Shared Pong geometry, game-state encoding and small helpers.
// The display renderer imports this package as well.
package pong_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int PADDLE_W   = 10;
  localparam int PADDLE_H   = 50;
  localparam int BALL_W     = 10;
  localparam int BALL_H     = 10;
  localparam int PADDLE1X   = 20;
  localparam int PADDLE2X   = 610;
  localparam int PADDLE_MIN = 1;
  localparam int PADDLE_MAX = 428;

  localparam int PADDLE_Y0  = (SCREEN_H - PADDLE_H) / 2;   // 215
  localparam int BALL_X0    = (SCREEN_W - BALL_W) / 2;     // 315
  localparam int BALL_Y0    = (SCREEN_H - BALL_H) / 2;     // 235

  // Ball travel limits: inside the 1-px border, and the paddle faces.
  localparam int BALL_Y_MIN   = 1;
  localparam int BALL_Y_MAX   = SCREEN_H - 1 - BALL_H;     // 469
  localparam int LEFT_HIT_X   = PADDLE1X + PADDLE_W;       // 30
  localparam int RIGHT_HIT_X  = PADDLE2X - BALL_W;         // 600
  localparam int LEFT_MISS_X  = 0;
  localparam int RIGHT_MISS_X = SCREEN_W - BALL_W;         // 630

  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAMEOVER} game_state_t;

  function automatic logic overlaps(input int ball_y, input int paddle_y);
    return (ball_y + BALL_H > paddle_y) && (ball_y < paddle_y + PADDLE_H);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
    return (score >= limit) ? score : score + 4'd1;
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: moves up/down by SPEED per frame tick, clamped to the play field.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_en,
  input  logic               i_up,
  input  logic               i_dn,
  output logic signed [31:0] o_y
);

  logic signed [31:0] r_y;
  logic signed [31:0] w_next_y;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_y = r_y;
    if (i_up && !i_dn) begin
      w_next_y = (r_y - SPEED < PADDLE_MIN) ? PADDLE_MIN : r_y - SPEED;
    end else if (i_dn && !i_up) begin
      w_next_y = (r_y + SPEED > PADDLE_MAX) ? PADDLE_MAX : r_y + SPEED;
    end
  end

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y <= PADDLE_Y0;
    end else if (i_tick && i_en) begin
      r_y <= w_next_y;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/pong_game_engine.sv
// Per-frame Pong state engine: serve delay, ball physics, scoring, game over.
// Everything advances only on FRAME_TICK; outputs are registered.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic               VGA_CLOCK,
  input  logic               RESET,
  input  logic               FRAME_TICK,
  input  logic               P1_UP,
  input  logic               P1_DN,
  input  logic               P2_UP,
  input  logic               P2_DN,
  input  logic               START,
  output logic signed [31:0] PADDLE1Y,
  output logic signed [31:0] PADDLE2Y,
  output logic signed [31:0] BALLX,
  output logic signed [31:0] BALLY,
  output logic [3:0]         SCORE1,
  output logic [3:0]         SCORE2,
  output logic               GAME_OVER,
  output logic               WINNER
);

  localparam logic [3:0]  WIN          = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_RELOAD = 16'(SERVE_FRAMES);

  game_state_t        r_state, w_state;
  logic signed [31:0] r_ball_x, w_ball_x, r_ball_y, w_ball_y;
  logic               r_dx_pos, w_dx_pos, r_dy_pos, w_dy_pos;
  logic [15:0]        r_serve_cnt, w_serve_cnt;
  logic [3:0]         r_score1, w_score1, r_score2, w_score2;
  logic               r_game_over, w_game_over, r_winner, w_winner;
  logic               r_last_scorer, w_last_scorer;   // 0 = player 1

  logic signed [31:0] w_paddle1_y, w_paddle2_y, w_nx, w_ny;
  logic               w_paddle_en, w_move, w_hit_l, w_hit_r, w_miss_l, w_miss_r;

  assign w_paddle_en = (r_state != GAMEOVER);

  paddle_ctrl #(.SPEED(PADDLE_SPEED)) u_paddle1 (
    .i_clk(VGA_CLOCK), .i_rst(RESET), .i_tick(FRAME_TICK), .i_en(w_paddle_en),
    .i_up(P1_UP), .i_dn(P1_DN), .o_y(w_paddle1_y)
  );

  paddle_ctrl #(.SPEED(PADDLE_SPEED)) u_paddle2 (
    .i_clk(VGA_CLOCK), .i_rst(RESET), .i_tick(FRAME_TICK), .i_en(w_paddle_en),
    .i_up(P2_UP), .i_dn(P2_DN), .o_y(w_paddle2_y)
  );

  // The serve tick that leaves the centre already moves the ball one step.
  assign w_move   = (r_state == PLAY) || (r_state == SERVE && r_serve_cnt == '0);
  assign w_nx     = r_dx_pos ? r_ball_x + BALL_SPEED : r_ball_x - BALL_SPEED;
  assign w_ny     = r_dy_pos ? r_ball_y + BALL_SPEED : r_ball_y - BALL_SPEED;
  assign w_hit_l  = (w_nx <= LEFT_HIT_X)  && overlaps(r_ball_y, w_paddle1_y);
  assign w_hit_r  = (w_nx >= RIGHT_HIT_X) && overlaps(r_ball_y, w_paddle2_y);
  assign w_miss_l = !r_dx_pos && !w_hit_l && (w_nx <= LEFT_MISS_X);
  assign w_miss_r =  r_dx_pos && !w_hit_r && (w_nx >= RIGHT_MISS_X);

  always_comb begin
    w_state       = r_state;
    w_ball_x      = r_ball_x;
    w_ball_y      = r_ball_y;
    w_dx_pos      = r_dx_pos;
    w_dy_pos      = r_dy_pos;
    w_serve_cnt   = r_serve_cnt;
    w_score1      = r_score1;
    w_score2      = r_score2;
    w_game_over   = r_game_over;
    w_winner      = r_winner;
    w_last_scorer = r_last_scorer;

    unique case (r_state)
      SERVE: begin
        if (r_serve_cnt == '0) w_state = PLAY;
        else                   w_serve_cnt = r_serve_cnt - 16'd1;
      end
      POINT: begin
        if (r_score1 == WIN || r_score2 == WIN) begin
          w_state     = GAMEOVER;
          w_game_over = 1'b1;
          w_winner    = r_last_scorer;
        end else begin
          w_state     = SERVE;
          w_ball_x    = BALL_X0;
          w_ball_y    = BALL_Y0;
          w_dx_pos    = !r_last_scorer;   // serve toward the player who conceded
          w_serve_cnt = SERVE_RELOAD;
        end
      end
      GAMEOVER: begin
        if (START) begin
          w_state     = SERVE;
          w_score1    = '0;
          w_score2    = '0;
          w_game_over = 1'b0;
          w_ball_x    = BALL_X0;
          w_ball_y    = BALL_Y0;
          w_dx_pos    = 1'b1;
          w_serve_cnt = SERVE_RELOAD;
        end
      end
      default: ;
    endcase

    if (w_move) begin
      if (w_miss_l) begin
        w_score2      = sat_inc(r_score2, WIN);
        w_last_scorer = 1'b1;
        w_state       = POINT;
      end else if (w_miss_r) begin
        w_score1      = sat_inc(r_score1, WIN);
        w_last_scorer = 1'b0;
        w_state       = POINT;
      end else begin
        if (w_ny <= BALL_Y_MIN) begin
          w_ball_y = BALL_Y_MIN;
          w_dy_pos = 1'b1;
        end else if (w_ny >= BALL_Y_MAX) begin
          w_ball_y = BALL_Y_MAX;
          w_dy_pos = 1'b0;
        end else begin
          w_ball_y = w_ny;
        end

        if (w_hit_l && !r_dx_pos) begin
          w_ball_x = LEFT_HIT_X;
          w_dx_pos = 1'b1;
        end else if (w_hit_r && r_dx_pos) begin
          w_ball_x = RIGHT_HIT_X;
          w_dx_pos = 1'b0;
        end else begin
          w_ball_x = w_nx;
        end
      end
    end
  end

  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      r_state       <= SERVE;
      r_ball_x      <= BALL_X0;
      r_ball_y      <= BALL_Y0;
      r_dx_pos      <= 1'b1;
      r_dy_pos      <= 1'b1;
      r_serve_cnt   <= SERVE_RELOAD;
      r_score1      <= '0;
      r_score2      <= '0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_last_scorer <= 1'b0;
    end else if (FRAME_TICK) begin
      r_state       <= w_state;
      r_ball_x      <= w_ball_x;
      r_ball_y      <= w_ball_y;
      r_dx_pos      <= w_dx_pos;
      r_dy_pos      <= w_dy_pos;
      r_serve_cnt   <= w_serve_cnt;
      r_score1      <= w_score1;
      r_score2      <= w_score2;
      r_game_over   <= w_game_over;
      r_winner      <= w_winner;
      r_last_scorer <= w_last_scorer;
    end
  end

  assign PADDLE1Y  = w_paddle1_y;
  assign PADDLE2Y  = w_paddle2_y;
  assign BALLX     = r_ball_x;
  assign BALLY     = r_ball_y;
  assign SCORE1    = r_score1;
  assign SCORE2    = r_score2;
  assign GAME_OVER = r_game_over;
  assign WINNER    = r_winner;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: hand-derived ball trajectory through
// serves, wall/paddle bounces and misses, then a played-out game to WIN_SCORE.
module tb_pong_game_engine;

  logic               VGA_CLOCK = 1'b0;
  logic               RESET = 1'b1, FRAME_TICK = 1'b0, START = 1'b0;
  logic               P1_UP = 1'b0, P1_DN = 1'b0, P2_UP = 1'b0, P2_DN = 1'b0;
  logic signed [31:0] PADDLE1Y, PADDLE2Y, BALLX, BALLY;
  logic [3:0]         SCORE1, SCORE2;
  logic               GAME_OVER, WINNER;

  int n_total = 0;
  int n_bad   = 0;
  int cur_t   = 0;

  pong_game_engine dut (
    .VGA_CLOCK(VGA_CLOCK), .RESET(RESET), .FRAME_TICK(FRAME_TICK),
    .P1_UP(P1_UP), .P1_DN(P1_DN), .P2_UP(P2_UP), .P2_DN(P2_DN), .START(START),
    .PADDLE1Y(PADDLE1Y), .PADDLE2Y(PADDLE2Y), .BALLX(BALLX), .BALLY(BALLY),
    .SCORE1(SCORE1), .SCORE2(SCORE2), .GAME_OVER(GAME_OVER), .WINNER(WINNER)
  );

  always #5 VGA_CLOCK = ~VGA_CLOCK;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check({tag, "_x"}, BALLX, ex);
    check({tag, "_y"}, BALLY, ey);
  endtask

  // Called and returns on a negedge; applies n back-to-back frame ticks.
  task automatic ticks(input int n);
    FRAME_TICK = 1'b1;
    repeat (n) @(negedge VGA_CLOCK);
    FRAME_TICK = 1'b0;
  endtask

  task automatic advance_to(input int t);
    ticks(t - cur_t);
    cur_t = t;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_p1y"}, PADDLE1Y, 215);
    check({tag, "_p2y"}, PADDLE2Y, 215);
    check_ball(tag, 315, 235);
    check({tag, "_s1"}, SCORE1, 0);
    check({tag, "_s2"}, SCORE2, 0);
    check({tag, "_go"}, GAME_OVER, 0);
    check({tag, "_win"}, WINNER, 0);
  endtask

  initial begin
    int  exp_s1;
    int  target;
    bit  done;

    repeat (2) @(negedge VGA_CLOCK);
    RESET = 1'b0;
    check_reset_values("rst");

    // Serve: P1 drives up into the wall, P2 presses both (no motion), START ignored.
    P1_UP = 1'b1; P2_UP = 1'b1; P2_DN = 1'b1; START = 1'b1;
    advance_to(1);
    START = 1'b0;
    check("p1_first_step", PADDLE1Y, 211);
    check("p2_both_held", PADDLE2Y, 215);
    check("serve_start_ignored", SCORE1, 0);
    advance_to(60);
    check("p1_clamp_top", PADDLE1Y, 1);
    check("p2_both_held_60", PADDLE2Y, 215);
    check_ball("serve_hold", 315, 235);
    advance_to(61);
    P1_UP = 1'b0; P2_UP = 1'b0; P2_DN = 1'b0;
    check("p1_stays_top", PADDLE1Y, 1);
    check_ball("serve_leave", 317, 237);

    // Point 1: bottom bounce, pass P2 (at 215) without contact, right miss.
    advance_to(176); check_ball("pre_bottom", 547, 467);
    advance_to(177); check_ball("bottom_bounce", 549, 469);
    @(negedge VGA_CLOCK);
    check_ball("no_tick_hold", 549, 469);
    advance_to(178); check_ball("after_bottom", 551, 467);
    advance_to(203); check_ball("past_p2_face", 601, 417);
    advance_to(217); check_ball("pre_miss_r", 629, 389);
    check("s1_before_miss", SCORE1, 0);
    advance_to(218);
    check("s1_after_miss", SCORE1, 1);
    check("s2_after_miss", SCORE2, 0);
    check_ball("miss_r_hold", 629, 389);
    advance_to(219);
    check_ball("point_centre", 315, 235);
    check("go_after_point", GAME_OVER, 0);

    // Position paddles: P2 to 55, P1 to 317.
    P2_UP = 1'b1; P1_DN = 1'b1;
    advance_to(259);
    P2_UP = 1'b0;
    check("p2_at_55", PADDLE2Y, 55);
    check("p1_at_161", PADDLE1Y, 161);
    advance_to(279); check_ball("serve2_hold", 315, 235);
    advance_to(280); check_ball("serve2_leave", 317, 233);
    advance_to(298);
    P1_DN = 1'b0;
    check("p1_at_317", PADDLE1Y, 317);
    check_ball("serve2_run", 353, 197);

    // Top bounce, P2 hit at 55, leftward run, P1 hit at BALLY.
    advance_to(395); check_ball("pre_top", 547, 3);
    advance_to(396); check_ball("top_bounce", 549, 1);
    advance_to(397); check_ball("after_top", 551, 3);
    advance_to(421); check_ball("pre_hit_r", 599, 51);
    advance_to(422); check_ball("hit_r", 600, 53);
    advance_to(423); check_ball("after_hit_r", 598, 55);
    P2_DN = 1'b1;
    advance_to(463);
    P2_DN = 1'b0;
    check("p2_back_215", PADDLE2Y, 215);
    check_ball("leftward", 518, 135);
    advance_to(630); check_ball("bottom2", 184, 469);
    advance_to(706); check_ball("pre_hit_l", 32, 317);
    advance_to(707); check_ball("hit_l", 30, 315);
    advance_to(708); check_ball("after_hit_l", 32, 313);

    // Top bounce, P2 hit at 215, then left miss with P1 far below the ball.
    advance_to(864); check_ball("top2", 344, 1);
    advance_to(991); check_ball("pre_hit_r2", 598, 255);
    advance_to(992); check_ball("hit_r2", 600, 257);
    advance_to(1098); check_ball("bottom3", 388, 469);
    advance_to(1277); check_ball("pass_l_face", 30, 111);
    advance_to(1291); check_ball("pre_miss_l", 2, 83);
    check("s2_before_miss", SCORE2, 0);
    advance_to(1292);
    check("s2_after_miss_l", SCORE2, 1);
    check("s1_unchanged", SCORE1, 1);
    check_ball("miss_l_hold", 2, 83);
    advance_to(1293); check_ball("point2_centre", 315, 235);
    advance_to(1353); check_ball("serve3_hold", 315, 235);
    advance_to(1354); check_ball("serve3_left", 313, 233);

    // Play out: P1 tracks the ball, P2 parks at the top until P1 reaches 9.
    exp_s1 = 1;
    done   = 1'b0;
    P2_UP  = 1'b1;
    for (int i = 0; i < 40000 && !done; i++) begin
      target = BALLY - 20;
      P1_UP  = (PADDLE1Y > target + 2);
      P1_DN  = (PADDLE1Y < target - 2);
      ticks(1);
      if (SCORE2 != 4'd1) begin
        check("p2_unexpected_point", SCORE2, 1);
        done = 1'b1;
      end else if (SCORE1 != exp_s1[3:0]) begin
        exp_s1++;
        check("p1_point", SCORE1, exp_s1);
        if (exp_s1 == 9) done = 1'b1;
      end
    end
    P1_UP = 1'b0; P1_DN = 1'b0;
    check("reach_win_score", SCORE1, 9);
    check("go_low_in_point", GAME_OVER, 0);
    ticks(1);
    check("game_over", GAME_OVER, 1);
    check("winner_p1", WINNER, 0);
    check("go_s1", SCORE1, 9);
    check("go_s2", SCORE2, 1);
    P2_UP = 1'b0; P2_DN = 1'b1;
    ticks(5);
    P2_DN = 1'b0;
    check("go_paddle_hold", PADDLE2Y, 1);
    check("go_hold", GAME_OVER, 1);
    check("go_s1_hold", SCORE1, 9);

    START = 1'b1;
    ticks(1);
    START = 1'b0;
    check("restart_s1", SCORE1, 0);
    check("restart_s2", SCORE2, 0);
    check("restart_go", GAME_OVER, 0);
    check_ball("restart_centre", 315, 235);
    ticks(60);
    check("restart_serve_hold", BALLX, 315);
    ticks(1);
    check("restart_dx_pos", BALLX, 317);

    // Reset coincident with a frame tick mid-play.
    ticks(3);
    RESET = 1'b1; FRAME_TICK = 1'b1;
    @(negedge VGA_CLOCK);
    RESET = 1'b0; FRAME_TICK = 1'b0;
    check_reset_values("rst_mid");
    ticks(61);
    check_ball("rst_serve_leave", 317, 237);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
